// File: rtl/ksram_fetch_sched_if.sv
`default_nettype none
// ============================================================================
// Module  : ksram_fetch_sched_if
// Brief   : Fetch-request and K-FIFO handshake bundle for ksram_fetch_sched.
// Rev     : 1.0  initial release
// ============================================================================
`ifndef MAX_SEQ_LENGTH
`define MAX_SEQ_LENGTH 64
`endif

interface ksram_fetch_sched_if #(
    parameter int ROW_W = $clog2(`MAX_SEQ_LENGTH)
) ();
    logic             mem_req_valid;
    logic             mem_req_ready;
    logic [ROW_W-1:0] mem_req_row;
    logic             mem_rsp_valid;
    logic             fifo_ready;
    logic             fifo_pop;

    modport master (
        output mem_req_valid, mem_req_row,
        input  mem_req_ready, mem_rsp_valid, fifo_ready, fifo_pop
    );

    modport slave (
        input  mem_req_valid, mem_req_row,
        output mem_req_ready, mem_rsp_valid, fifo_ready, fifo_pop
    );
endinterface

`default_nettype wire

// File: rtl/ksram_fetch_sched.sv
`default_nettype none
// ============================================================================
// Module  : ksram_fetch_sched
// Brief   : Credit-based K-row fetch scheduler for one attention pass.
// Options : KSRAM_FETCH_SCHED_PERF_EN adds saturating performance counters.
// Rev     : 1.0  initial release
// ============================================================================
`ifndef MAX_SEQ_LENGTH
`define MAX_SEQ_LENGTH 64
`endif

module ksram_fetch_sched #(
    parameter int FIFO_DEPTH   = `MAX_SEQ_LENGTH,
    parameter int MAX_Q_BLOCKS = 64,
    parameter int ROW_W        = $clog2(`MAX_SEQ_LENGTH)
) (
    input  wire                            clk,
    input  wire                            rst,
    input  wire                            start,
    input  wire [ROW_W:0]                  cfg_seq_len,
    input  wire [$clog2(MAX_Q_BLOCKS):0]   cfg_num_q_blocks,
    ksram_fetch_sched_if.master            bus,
    output logic                           q_block_done,
    output logic                           busy,
    output logic                           done,
    output logic                           err
`ifdef KSRAM_FETCH_SCHED_PERF_EN
    ,
    output logic [31:0]                    perf_stall_credit,
    output logic [31:0]                    perf_stall_mem,
    output logic [31:0]                    perf_cycles
`endif
);
    localparam int                 c_qb_w    = $clog2(MAX_Q_BLOCKS) + 1;
    localparam int                 c_cr_w    = $clog2(FIFO_DEPTH + 1);
    localparam logic [c_cr_w-1:0]  c_full    = c_cr_w'(FIFO_DEPTH);
    localparam logic [c_cr_w-1:0]  c_cr_one  = c_cr_w'(1);
    localparam logic [ROW_W:0]     c_len_one = (ROW_W + 1)'(1);
    localparam logic [c_qb_w-1:0]  c_blk_one = c_qb_w'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             r_state, w_state_nx;
    logic               r_valid, w_valid_nx;
    logic [ROW_W-1:0]   r_row, w_row_nx;
    logic [c_qb_w-1:0]  r_blk, w_blk_nx;
    logic [c_qb_w-1:0]  r_blk_done, w_blk_done_nx;
    logic [c_qb_w-1:0]  r_num_blk, w_num_blk_nx;
    logic [ROW_W:0]     r_seq_len, w_seq_len_nx;
    logic [ROW_W:0]     r_pop_cnt, w_pop_cnt_nx;
    logic [c_cr_w-1:0]  r_credits, w_credits_nx;
    logic               r_qbd, w_qbd_nx;
    logic               r_done, r_err;
    logic               w_accept, w_pop_ok, w_err_evt;
    logic               w_last_row, w_last_blk, w_last_pop, w_last_pop_blk;

    always_comb begin
        w_accept       = r_valid && bus.mem_req_ready;
        // Pops are only counted while a pass owns the FIFO and a credit is outstanding.
        w_pop_ok       = bus.fifo_pop && (r_state == S_FETCH || r_state == S_DRAIN)
                         && (r_credits != c_full);
        w_err_evt      = (bus.mem_rsp_valid && !bus.fifo_ready)
                         || (bus.fifo_pop && (r_state == S_IDLE || r_credits == c_full));
        w_last_row     = ({1'b0, r_row} == r_seq_len - c_len_one);
        w_last_blk     = (r_blk == r_num_blk - c_blk_one);
        w_last_pop     = (r_pop_cnt == r_seq_len - c_len_one);
        w_last_pop_blk = (r_blk_done == r_num_blk - c_blk_one);

        w_state_nx    = r_state;
        w_valid_nx    = r_valid;
        w_row_nx      = r_row;
        w_blk_nx      = r_blk;
        w_blk_done_nx = r_blk_done;
        w_num_blk_nx  = r_num_blk;
        w_seq_len_nx  = r_seq_len;
        w_pop_cnt_nx  = r_pop_cnt;
        w_credits_nx  = r_credits;
        w_qbd_nx      = 1'b0;

        if (r_state == S_FETCH || r_state == S_DRAIN) begin
            if (w_accept && !w_pop_ok) begin
                w_credits_nx = r_credits - c_cr_one;
            end else if (w_pop_ok && !w_accept) begin
                w_credits_nx = r_credits + c_cr_one;
            end
            if (w_pop_ok) begin
                if (w_last_pop) begin
                    w_pop_cnt_nx = '0;
                    w_qbd_nx     = 1'b1;
                    if (r_blk_done != r_num_blk) begin
                        w_blk_done_nx = r_blk_done + c_blk_one;
                    end
                end else begin
                    w_pop_cnt_nx = r_pop_cnt + c_len_one;
                end
            end
        end

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_seq_len_nx  = cfg_seq_len;
                    w_num_blk_nx  = cfg_num_q_blocks;
                    w_row_nx      = '0;
                    w_blk_nx      = '0;
                    w_blk_done_nx = '0;
                    w_pop_cnt_nx  = '0;
                    w_credits_nx  = c_full;
                    if (cfg_seq_len == '0 || cfg_num_q_blocks == '0) begin
                        w_state_nx = S_DONE;
                    end else begin
                        w_state_nx = S_FETCH;
                        w_valid_nx = 1'b1;
                    end
                end
            end
            S_FETCH: begin
                if (w_accept) begin
                    if (w_last_row) begin
                        w_row_nx = '0;
                        if (w_last_blk) begin
                            w_state_nx = S_DRAIN;
                        end else begin
                            w_blk_nx = r_blk + c_blk_one;
                        end
                    end else begin
                        w_row_nx = r_row + ROW_W'(1);
                    end
                end
                w_valid_nx = (w_state_nx == S_FETCH) && (w_credits_nx != '0);
            end
            S_DRAIN: begin
                w_valid_nx = 1'b0;
                if (w_pop_ok && w_last_pop && w_last_pop_blk) begin
                    w_state_nx = S_DONE;
                end
            end
            S_DONE: begin
                w_valid_nx = 1'b0;
                w_state_nx = S_IDLE;
            end
            default: begin
                w_valid_nx = 1'b0;
                w_state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_valid    <= 1'b0;
            r_row      <= '0;
            r_blk      <= '0;
            r_blk_done <= '0;
            r_num_blk  <= '0;
            r_seq_len  <= '0;
            r_pop_cnt  <= '0;
            r_credits  <= c_full;
            r_qbd      <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_valid    <= w_valid_nx;
            r_row      <= w_row_nx;
            r_blk      <= w_blk_nx;
            r_blk_done <= w_blk_done_nx;
            r_num_blk  <= w_num_blk_nx;
            r_seq_len  <= w_seq_len_nx;
            r_pop_cnt  <= w_pop_cnt_nx;
            r_credits  <= w_credits_nx;
            r_qbd      <= w_qbd_nx;
            r_done     <= (r_state == S_DONE);
            r_err      <= r_err | w_err_evt;
        end
    end

    assign bus.mem_req_valid = r_valid;
    assign bus.mem_req_row   = r_row;
    assign q_block_done      = r_qbd;
    assign busy              = (r_state == S_FETCH) || (r_state == S_DRAIN);
    assign done              = r_done;
    assign err               = r_err;

`ifdef KSRAM_FETCH_SCHED_PERF_EN
    logic [31:0] r_perf_stall_credit, r_perf_stall_mem, r_perf_cycles;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_stall_credit <= '0;
            r_perf_stall_mem    <= '0;
            r_perf_cycles       <= '0;
        end else if (r_state == S_IDLE) begin
            if (start) begin
                r_perf_stall_credit <= '0;
                r_perf_stall_mem    <= '0;
                r_perf_cycles       <= '0;
            end
        end else begin
            if (r_state == S_FETCH && r_credits == '0 && r_perf_stall_credit != '1) begin
                r_perf_stall_credit <= r_perf_stall_credit + 32'd1;
            end
            if (r_valid && !bus.mem_req_ready && r_perf_stall_mem != '1) begin
                r_perf_stall_mem <= r_perf_stall_mem + 32'd1;
            end
            if (busy && r_perf_cycles != '1) begin
                r_perf_cycles <= r_perf_cycles + 32'd1;
            end
        end
    end

    assign perf_stall_credit = r_perf_stall_credit;
    assign perf_stall_mem    = r_perf_stall_mem;
    assign perf_cycles       = r_perf_cycles;
`endif

endmodule

`default_nettype wire
